text_cursor_ctrl: RTL and testbench

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

---
 rtl/text_cursor_ctrl_pkg.sv | 23 ++
 rtl/text_cursor_ctrl.sv | 134 +++++++++++++
 tb/tb_text_cursor_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_cursor_ctrl_pkg.sv
// Shared constants, state encoding and cell-address packing for the text cursor controller.
package text_cursor_ctrl_pkg;

    localparam int         COLS_DEF  = 70;
    localparam int         ROWS_DEF  = 32;
    localparam logic [7:0] BLANK_DEF = 8'h20;

    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_BS    = 8'h08;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

    function automatic logic [31:0] pack_addr(input logic [6:0] x, input logic [4:0] y);
        return {20'd0, x, y};
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_cursor_ctrl.sv
// Keyboard-driven text cursor: writes characters to a character buffer, clears screen/lines.
// Latency: accepted key appears as a registered write (and new cursor) one cycle later.
// Backpressure: key_ready low during full-screen init clear and single-line clears.
module text_cursor_ctrl
    import text_cursor_ctrl_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = BLANK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    output logic        key_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    logic [1:0] state;
    logic [6:0] clr_x;
    logic [4:0] clr_y;
    logic [4:0] next_row;

    assign next_row = (cur_y == Y_MAX) ? 5'd0 : cur_y + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_x     <= '0;
            clr_y     <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    wr_en   <= 1'b1;
                    wr_addr <= pack_addr(clr_x, clr_y);
                    wr_data <= BLANK;
                    if (clr_x == X_MAX) begin
                        clr_x <= '0;
                        if (clr_y == Y_MAX) begin
                            clr_y <= '0;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            clr_y <= clr_y + 5'd1;
                        end
                    end else begin
                        clr_x <= clr_x + 7'd1;
                    end
                end

                ST_CLR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= pack_addr(clr_x, cur_y);
                    wr_data <= BLANK;
                    if (clr_x == X_MAX) begin
                        clr_x <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_x <= clr_x + 7'd1;
                    end
                end

                ST_IDLE: begin
                    // key_ready rises one cycle after a clear's last write
                    wr_en     <= 1'b0;
                    key_ready <= 1'b1;
                    if (key_valid && key_ready) begin
                        if (is_printable(key_ascii)) begin
                            wr_en   <= 1'b1;
                            wr_addr <= pack_addr(cur_x, cur_y);
                            wr_data <= key_ascii;
                            if (cur_x != X_MAX) begin
                                cur_x <= cur_x + 7'd1;
                            end else begin
                                cur_x     <= '0;
                                cur_y     <= next_row;
                                clr_x     <= '0;
                                state     <= ST_CLR;
                                busy      <= 1'b1;
                                key_ready <= 1'b0;
                            end
                        end else if (key_ascii == KEY_ENTER) begin
                            cur_x     <= '0;
                            cur_y     <= next_row;
                            clr_x     <= '0;
                            state     <= ST_CLR;
                            busy      <= 1'b1;
                            key_ready <= 1'b0;
                        end else if (key_ascii == KEY_BS) begin
                            if (cur_x != 7'd0) begin
                                cur_x   <= cur_x - 7'd1;
                                wr_en   <= 1'b1;
                                wr_addr <= pack_addr(cur_x - 7'd1, cur_y);
                                wr_data <= BLANK;
                            end else if (cur_y != 5'd0) begin
                                cur_x   <= X_MAX;
                                cur_y   <= cur_y - 5'd1;
                                wr_en   <= 1'b1;
                                wr_addr <= pack_addr(X_MAX, cur_y - 5'd1);
                                wr_data <= BLANK;
                            end
                        end
                    end
                end

                default: begin
                    state     <= ST_INIT;
                    clr_x     <= '0;
                    clr_y     <= '0;
                    wr_en     <= 1'b0;
                    key_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Bench for text_cursor_ctrl: directed vectors plus random keys against a screen-level model.
module tb_text_cursor_ctrl;

    localparam int NC = 70;
    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_ascii;
    logic        key_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    text_cursor_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    typedef struct {
        int         sx;
        int         sy;
        logic [7:0] key;
        bit         ewr;
        int         ewx;
        int         ewy;
        int         ewd;
        int         ex;
        int         ey;
        bit         eclr;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  mx = 0;
    int  my = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: every accepted key becomes an ordered list of expected cell writes
    task automatic push_row(input int y);
        for (int x = 0; x < NC; x++) exp_q.push_back('{x, y, 32'h20});
    endtask

    task automatic push_init();
        for (int y = 0; y < NR; y++) push_row(y);
    endtask

    task automatic model_accept(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            exp_q.push_back('{mx, my, int'(k)});
            if (mx < NC - 1) mx++;
            else begin
                mx = 0;
                my = (my + 1) % NR;
                push_row(my);
            end
        end else if (k == 8'h0D) begin
            mx = 0;
            my = (my + 1) % NR;
            push_row(my);
        end else if (k == 8'h08) begin
            if (mx > 0) begin
                mx--;
                exp_q.push_back('{mx, my, 32'h20});
            end else if (my > 0) begin
                mx = NC - 1;
                my--;
                exp_q.push_back('{mx, my, 32'h20});
            end
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", wr_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", wr_addr, 32'(w.x * 32 + w.y));
                chk("write_data", 32'(wr_data), 32'(w.d));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (key_ready !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        chk("wait_ready", 32'(key_ready), 32'd1);
    endtask

    task automatic press(input logic [7:0] k);
        wait_ready();
        key_valid = 1'b1;
        key_ascii = k;
        model_accept(k);
        step();
        key_valid = 1'b0;
    endtask

    task automatic goto_xy(input int tx, input int ty);
        while (my != ty) press(8'h0D);
        while (mx > tx) press(8'h08);
        while (mx < tx) press(8'h61);
    endtask

    vec_t vecs[11];

    initial begin
        int n;
        vecs[0]  = '{0,  0,  8'h41, 1, 0,  0,  8'h41, 1,  0,  0};
        vecs[1]  = '{69, 5,  8'h5A, 1, 69, 5,  8'h5A, 0,  6,  1};
        vecs[2]  = '{3,  31, 8'h0D, 0, 0,  0,  0,     0,  0,  1};
        vecs[3]  = '{0,  4,  8'h08, 1, 69, 3,  8'h20, 69, 3,  0};
        vecs[4]  = '{0,  0,  8'h08, 0, 0,  0,  0,     0,  0,  0};
        vecs[5]  = '{5,  2,  8'h08, 1, 4,  2,  8'h20, 4,  2,  0};
        vecs[6]  = '{10, 7,  8'h7E, 1, 10, 7,  8'h7E, 11, 7,  0};
        vecs[7]  = '{10, 7,  8'h1B, 0, 0,  0,  0,     10, 7,  0};
        vecs[8]  = '{69, 31, 8'h20, 1, 69, 31, 8'h20, 0,  0,  1};
        vecs[9]  = '{7,  9,  8'h0D, 0, 0,  0,  0,     0,  10, 1};
        vecs[10] = '{8,  8,  8'h7F, 0, 0,  0,  0,     8,  8,  0};

        rst = 1'b1;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        step();
        step();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_key_ready", 32'(key_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_cursor", {cur_x, cur_y}, 0);

        // Full-screen clear: count consecutive write cycles
        push_init();
        rst = 1'b0;
        step();
        n = 0;
        while (wr_en === 1'b1 && n < 3000) begin
            n++;
            step();
        end
        chk("init_write_cycles", n, NR * NC);
        chk("init_ready_after", 32'(key_ready), 1);
        chk("init_busy_after", 32'(busy), 0);

        // Back-to-back printable keys
        key_valid = 1'b1;
        key_ascii = 8'h41;
        model_accept(8'h41);
        step();
        chk("b2b_a_wr_en", 32'(wr_en), 1);
        chk("b2b_a_addr", wr_addr, 0);
        chk("b2b_a_data", 32'(wr_data), 32'h41);
        chk("b2b_a_cursor", {cur_x, cur_y}, {7'd1, 5'd0});
        chk("b2b_ready", 32'(key_ready), 1);
        key_ascii = 8'h42;
        model_accept(8'h42);
        step();
        key_valid = 1'b0;
        chk("b2b_b_wr_en", 32'(wr_en), 1);
        chk("b2b_b_addr", wr_addr, 32);
        chk("b2b_b_data", 32'(wr_data), 32'h42);
        chk("b2b_b_cursor", {cur_x, cur_y}, {7'd2, 5'd0});

        foreach (vecs[i]) begin
            goto_xy(vecs[i].sx, vecs[i].sy);
            wait_ready();
            key_valid = 1'b1;
            key_ascii = vecs[i].key;
            model_accept(vecs[i].key);
            step();
            key_valid = 1'b0;
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].ewr));
            if (vecs[i].ewr) begin
                chk($sformatf("vec%0d_addr", i), wr_addr, 32'(vecs[i].ewx * 32 + vecs[i].ewy));
                chk($sformatf("vec%0d_data", i), 32'(wr_data), 32'(vecs[i].ewd));
            end
            chk($sformatf("vec%0d_cursor", i), {cur_x, cur_y},
                {7'(vecs[i].ex), 5'(vecs[i].ey)});
            chk($sformatf("vec%0d_ready", i), 32'(key_ready), 32'(!vecs[i].eclr));
            if (vecs[i].eclr) begin
                for (int c = 0; c < NC; c++) begin
                    step();
                    chk($sformatf("vec%0d_clr_wr_en", i), 32'(wr_en), 1);
                    chk($sformatf("vec%0d_clr_addr", i), wr_addr, 32'(c * 32 + vecs[i].ey));
                    chk($sformatf("vec%0d_clr_data", i), 32'(wr_data), 32'h20);
                    chk($sformatf("vec%0d_clr_ready", i), 32'(key_ready), 0);
                    chk($sformatf("vec%0d_clr_cursor", i), {cur_x, cur_y},
                        {7'(vecs[i].ex), 5'(vecs[i].ey)});
                end
                step();
                chk($sformatf("vec%0d_ready_after", i), 32'(key_ready), 1);
            end
        end

        // Reset in the middle of a line clear
        goto_xy(12, 14);
        press(8'h0D);
        for (int c = 0; c < 30; c++) step();
        chk("midclr_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        exp_q.delete();
        mx = 0;
        my = 0;
        push_init();
        chk("midclr_rst_wr_en", 32'(wr_en), 0);
        chk("midclr_rst_cursor", {cur_x, cur_y}, 0);
        chk("midclr_rst_busy", 32'(busy), 1);
        rst = 1'b0;
        step();
        chk("midclr_init_wr_en", 32'(wr_en), 1);
        chk("midclr_init_addr", wr_addr, 0);
        wait_ready();

        // Random keys
        for (int c = 0; c < 6000; c++) begin
            int r;
            logic [7:0] k;
            r = $urandom_range(0, 99);
            if (r < 70) k = 8'($urandom_range(32, 126));
            else if (r < 78) k = 8'h0D;
            else if (r < 90) k = 8'h08;
            else begin
                k = 8'($urandom_range(0, 255));
                if ((k >= 8'h20 && k <= 8'h7E) || k == 8'h0D || k == 8'h08) k = 8'h01;
            end
            key_valid = ($urandom_range(0, 3) != 0);
            key_ascii = k;
            if (key_valid && key_ready) model_accept(k);
            step();
            chk("rand_cursor", {cur_x, cur_y}, {7'(mx), 5'(my)});
        end
        key_valid = 1'b0;
        wait_ready();
        step();
        wait_ready();
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
